// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, arbiter FSM encoding and default datapath width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PTRW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PTRW-1:0] gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTRW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NREQ requesters with round-robin grants; optional grant stats (ALU_ARB_STATS_EN).
// Latency: accept in cycle T, ALU executes in T+1, rsp_valid from T+2; initiation interval 3 cycles.
// Backpressure: result held in RESP until rsp_ready; no requester is granted while EXEC or RESP is active.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_lhs,
    input  logic [NREQ*WIDTH-1:0] req_rhs,
    input  logic [NREQ*3-1:0]     req_func,
    output logic [WIDTH-1:0]      alu_lhs,
    output logic [WIDTH-1:0]      alu_rhs,
    output logic [2:0]            alu_func,
    input  logic [WIDTH-1:0]      alu_res,
    input  logic                  alu_zero,
    input  logic                  alu_neg,
`ifdef ALU_ARB_STATS_EN
    output logic [NREQ*16-1:0]    grant_cnt,
    input  logic                  stats_clr,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_res,
    output logic                  rsp_zero,
    output logic                  rsp_neg
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_q, state_d;
    logic [PTRW-1:0]  rr_ptr_q;
    logic [NREQ-1:0]  arb_gnt;
    logic [PTRW-1:0]  arb_idx;
    logic             arb_any;
    logic             accept;

    logic [WIDTH-1:0] lhs_q, rhs_q, res_q;
    logic [2:0]       func_q;
    logic [IDW-1:0]   id_q;
    logic             zero_q, neg_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign accept    = (state_q == IDLE) && arb_any;
    assign req_ready = (state_q == IDLE) ? arb_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers only load on a grant, so the ALU inputs stay quiet between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            func_q   <= '0;
            id_q     <= '0;
        end else if (accept) begin
            rr_ptr_q <= PTRW'(rr_next(32'(arb_idx), NREQ));
            lhs_q    <= req_lhs[int'(arb_idx)*WIDTH +: WIDTH];
            rhs_q    <= req_rhs[int'(arb_idx)*WIDTH +: WIDTH];
            func_q   <= req_func[int'(arb_idx)*3 +: 3];
            id_q     <= IDW'(arb_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == EXEC) begin
            res_q  <= alu_res;
            zero_q <= alu_zero;
            neg_q  <= alu_neg;
        end
    end

    assign alu_lhs   = lhs_q;
    assign alu_rhs   = rhs_q;
    assign alu_func  = func_q;

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_res   = res_q;
    assign rsp_zero  = zero_q;
    assign rsp_neg   = neg_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    // Clear wins over a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (accept && (cnt_q[arb_idx] != 16'hFFFF)) begin
            cnt_q[arb_idx] <= cnt_q[arb_idx] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
        assign grant_cnt[gi*16 +: 16] = cnt_q[gi];
    end
`endif

endmodule
